vrf_rport_sequencer: RTL and testbench

//  Read-side initiator for one vrf read port. Accepts a burst request (base row, length).

---
 rtl/vrf_rport_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_vrf_rport_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_rport_sequencer.sv
// Burst read sequencer for one vrf read port: issues row reads under a credit limit and streams rows out over valid/ready.
// First beat appears RD_LATENCY+2 cycles after accept; reads stall when the FIFO plus in-flight reads reach FIFO_DEPTH.
`timescale 1ns/1ps

module vrf_rport_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_vld,
   input  logic [W-1:0]     push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [W-1:0]     pop_dat,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign pop_vld = (count != '0);
   assign pop_dat = mem[rd_ptr];
   assign wr_en   = push_vld && (count != CNT_W'(DEPTH));
   assign rd_en   = pop_vld && pop_rdy;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module vrf_rport_sequencer #(
   parameter int MEM_DEPTH  = 512,
   parameter int MEM_WIDTH  = 32,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = $clog2(MEM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [ADDR_W-1:0]    req_base_i,
   input  logic [ADDR_W:0]      req_len_i,
   output logic [ADDR_W-1:0]    raddr_o,
   output logic                 ren_o,
   output logic                 oreg_en_o,
   input  logic [MEM_WIDTH-1:0] dout_i,
   output logic                 data_valid_o,
   input  logic                 data_ready_i,
   output logic [MEM_WIDTH-1:0] data_o,
   output logic                 data_last_o,
   output logic                 busy_o
);
   localparam int LEN_W  = ADDR_W + 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                 state;
   state_t                 state_d;
   logic [ADDR_W-1:0]      addr_q;
   logic [LEN_W-1:0]       remaining_q;
   logic [RD_LATENCY-1:0]  pipe_vld;
   logic [RD_LATENCY-1:0]  pipe_last;
   logic [CNT_W-1:0]       inflight_count;
   logic [FCNT_W-1:0]      fifo_count;
   logic                   credit_ok;
   logic                   accept;
   logic                   issue;
   logic                   issue_last;
   logic                   fifo_vld;
   logic [MEM_WIDTH:0]     fifo_dat;

   assign req_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);
   assign accept      = req_valid_i && req_ready_o;
   assign raddr_o     = addr_q;

   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < RD_LATENCY; i++)
         inflight_count = inflight_count + CNT_W'(pipe_vld[i]);
   end

   // Credits cover both buffered rows and reads still travelling through the vrf.
   assign credit_ok  = (CNT_W'(fifo_count) + inflight_count) < CNT_W'(FIFO_DEPTH);
   assign issue      = (state == ISSUE) && credit_ok;
   assign issue_last = issue && (remaining_q == LEN_W'(1));
   assign ren_o      = issue;

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept && (req_len_i != '0)) state_d = ISSUE;
         ISSUE:   if (issue_last) state_d = DRAIN;
         DRAIN:   if ((inflight_count == '0) && !fifo_vld) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            addr_q      <= req_base_i;
            remaining_q <= req_len_i;
         end else if (issue) begin
            addr_q      <= (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
         end
      end
   end

   generate
      if (RD_LATENCY == 1) begin : g_lat1
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               pipe_vld  <= '0;
               pipe_last <= '0;
            end else begin
               pipe_vld  <= issue;
               pipe_last <= issue_last;
            end
         end
         assign oreg_en_o = 1'b0;
      end else begin : g_latn
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               pipe_vld  <= '0;
               pipe_last <= '0;
            end else begin
               pipe_vld  <= {pipe_vld[RD_LATENCY-2:0], issue};
               pipe_last <= {pipe_last[RD_LATENCY-2:0], issue_last};
            end
         end
         assign oreg_en_o = pipe_vld[0];
      end
   endgenerate

   vrf_rport_fifo #(
      .W     (MEM_WIDTH + 1),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (FCNT_W)
   ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push_vld (pipe_vld[RD_LATENCY-1]),
      .push_dat ({pipe_last[RD_LATENCY-1], dout_i}),
      .pop_vld  (fifo_vld),
      .pop_rdy  (data_ready_i),
      .pop_dat  (fifo_dat),
      .count    (fifo_count)
   );

   // Storage is not reset, so the payload is masked to zero whenever nothing is offered.
   assign data_valid_o = fifo_vld;
   assign data_o       = fifo_vld ? fifo_dat[MEM_WIDTH-1:0] : '0;
   assign data_last_o  = fifo_vld && fifo_dat[MEM_WIDTH];
endmodule

// File: tb/tb_vrf_rport_sequencer.sv
// Directed and randomised bench for vrf_rport_sequencer with a behavioural vrf read model.
`timescale 1ns/1ps

module tb_vrf_rport_sequencer;
   localparam int MEM_DEPTH  = 512;
   localparam int MEM_WIDTH  = 32;
   localparam int RD_LATENCY = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = 9;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b0;
   logic                 req_valid_i = 1'b0;
   logic                 req_ready_o;
   logic [ADDR_W-1:0]    req_base_i = '0;
   logic [ADDR_W:0]      req_len_i = '0;
   logic [ADDR_W-1:0]    raddr_o;
   logic                 ren_o;
   logic                 oreg_en_o;
   logic [MEM_WIDTH-1:0] dout_i;
   logic                 data_valid_o;
   logic                 data_ready_i = 1'b1;
   logic [MEM_WIDTH-1:0] data_o;
   logic                 data_last_o;
   logic                 busy_o;

   vrf_rport_sequencer #(
      .MEM_DEPTH  (MEM_DEPTH),
      .MEM_WIDTH  (MEM_WIDTH),
      .RD_LATENCY (RD_LATENCY),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_base_i   (req_base_i),
      .req_len_i    (req_len_i),
      .raddr_o      (raddr_o),
      .ren_o        (ren_o),
      .oreg_en_o    (oreg_en_o),
      .dout_i       (dout_i),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i),
      .data_o       (data_o),
      .data_last_o  (data_last_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] row_val(input int r);
      return 32'hA500_0000 ^ (32'(r) * 32'h0001_0003);
   endfunction

   // vrf read model: dout is valid exactly RD_LATENCY cycles after ren, garbage otherwise.
   logic              va [RD_LATENCY];
   logic [ADDR_W-1:0] aa [RD_LATENCY];
   always @(posedge clk) begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
         va[i] <= va[i-1];
         aa[i] <= aa[i-1];
      end
      va[0] <= ren_o;
      aa[0] <= raddr_o;
   end
   assign dout_i = (va[RD_LATENCY-1] === 1'b1) ? row_val(int'(aa[RD_LATENCY-1])) : 32'hDEAD_BEEF;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   logic [ADDR_W-1:0] ren_q[$];
   logic [32:0]       beat_q[$];
   int                occ = 0;
   int                max_occ = 0;
   int                first_vld = -1;
   int                first_pop = -1;
   int                last_pop = -1;
   int                stab_err = 0;
   bit                hold_prev = 0;
   logic [32:0]       prev_beat = '0;

   always @(negedge clk) begin
      if (!rstn) begin
         occ       = 0;
         hold_prev = 0;
      end else begin
         if (ren_o) ren_q.push_back(raddr_o);
         if (data_valid_o && first_vld < 0) first_vld = cyc;
         if (hold_prev && !(data_valid_o && {data_last_o, data_o} == prev_beat)) stab_err++;
         if (data_valid_o && data_ready_i) begin
            beat_q.push_back({data_last_o, data_o});
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         occ = occ + (ren_o ? 1 : 0) - ((data_valid_o && data_ready_i) ? 1 : 0);
         if (occ > max_occ) max_occ = occ;
         hold_prev = data_valid_o && !data_ready_i;
         prev_beat = {data_last_o, data_o};
      end
   end

   task automatic start_req(input int base, input int len, output int acc);
      ren_q.delete();
      beat_q.delete();
      first_vld = -1;
      first_pop = -1;
      last_pop  = -1;
      max_occ   = 0;
      @(posedge clk); #1;
      req_valid_i = 1'b1;
      req_base_i  = ADDR_W'(base);
      req_len_i   = (ADDR_W+1)'(len);
      @(negedge clk); #1;
      acc = cyc;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
   endtask

   // mode 0: ready always high; 1: ready low for 20 cycles; 2: random ready
   task automatic run_burst(input string nm, input int base, input int len, input int mode,
                            input int exp_beats, input int exp_lat);
      int acc;
      int k;
      int errs;
      int budget;
      bit done;
      data_ready_i = (mode == 1) ? 1'b0 : 1'b1;
      start_req(base, len, acc);
      budget = 100 + 8 * len;
      done = 0;
      k = 0;
      while (!done && k < budget) begin
         if (mode == 1 && k == 20) begin
            check({nm, "_bp_reads"}, 64'(ren_q.size()), 64'(FIFO_DEPTH));
            check({nm, "_bp_ren_idle"}, 64'(ren_o), 64'(0));
            data_ready_i = 1'b1;
         end
         if (mode == 2) data_ready_i = 1'($urandom_range(0, 1));
         @(negedge clk); #1;
         if (!busy_o) done = 1;
         else begin
            @(posedge clk); #1;
            k++;
         end
      end
      if (!done) check({nm, "_timeout"}, 64'(1), 64'(0));
      check({nm, "_req_ready"}, 64'(req_ready_o), 64'(1));
      check({nm, "_beats"}, 64'(beat_q.size()), 64'(exp_beats));
      check({nm, "_reads"}, 64'(ren_q.size()), 64'(exp_beats));
      errs = 0;
      for (int i = 0; i < exp_beats; i++) begin
         if (i < ren_q.size() && ren_q[i] != ADDR_W'((base + i) % MEM_DEPTH)) errs++;
         if (i < beat_q.size() && beat_q[i] != {i == exp_beats - 1, row_val((base + i) % MEM_DEPTH)}) errs++;
      end
      check({nm, "_order"}, 64'(errs), 64'(0));
      check({nm, "_credit"}, 64'(max_occ <= FIFO_DEPTH), 64'(1));
      if (exp_lat >= 0) check({nm, "_latency"}, 64'(first_vld - acc), 64'(exp_lat));
      if (mode == 0 && exp_beats > 0) check({nm, "_span"}, 64'(last_pop - first_pop), 64'(exp_beats - 1));
   endtask

   typedef struct {
      int base;
      int len;
      int mode;
      int exp_beats;
      int exp_lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int acc;
      int k;
      vecs[0] = '{base: 0,   len: 8,   mode: 0, exp_beats: 8,   exp_lat: 4};
      vecs[1] = '{base: 510, len: 4,   mode: 0, exp_beats: 4,   exp_lat: 4};
      vecs[2] = '{base: 0,   len: 16,  mode: 1, exp_beats: 16,  exp_lat: 4};
      vecs[3] = '{base: 7,   len: 0,   mode: 0, exp_beats: 0,   exp_lat: -1};
      vecs[4] = '{base: 100, len: 1,   mode: 0, exp_beats: 1,   exp_lat: 4};
      vecs[5] = '{base: 300, len: 512, mode: 0, exp_beats: 512, exp_lat: 4};
      vecs[6] = '{base: 5,   len: 9,   mode: 2, exp_beats: 9,   exp_lat: 4};

      #3;
      check("rst_req_ready", 64'(req_ready_o), 64'(1));
      check("rst_ren", 64'(ren_o), 64'(0));
      check("rst_oreg", 64'(oreg_en_o), 64'(0));
      check("rst_valid", 64'(data_valid_o), 64'(0));
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_raddr", 64'(raddr_o), 64'(0));
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;

      for (int i = 0; i < 7; i++)
         run_burst($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, vecs[i].mode,
                   vecs[i].exp_beats, vecs[i].exp_lat);

      // Reset in the middle of a burst, after three beats have been consumed.
      data_ready_i = 1'b1;
      start_req(0, 8, acc);
      k = 0;
      while (beat_q.size() < 3 && k < 100) begin
         @(negedge clk); #1;
         k++;
      end
      check("midrst_pre_beats", 64'(beat_q.size()), 64'(3));
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      check("midrst_ren", 64'(ren_o), 64'(0));
      check("midrst_valid", 64'(data_valid_o), 64'(0));
      check("midrst_data", 64'(data_o), 64'(0));
      check("midrst_last", 64'(data_last_o), 64'(0));
      check("midrst_req_ready", 64'(req_ready_o), 64'(1));
      check("midrst_busy", 64'(busy_o), 64'(0));
      check("midrst_oreg", 64'(oreg_en_o), 64'(0));
      check("midrst_raddr", 64'(raddr_o), 64'(0));
      @(posedge clk); #1;
      rstn = 1'b1;
      ren_q.delete();
      beat_q.delete();
      repeat (5) @(negedge clk);
      #1;
      check("postrst_no_reads", 64'(ren_q.size()), 64'(0));
      check("postrst_no_beats", 64'(beat_q.size()), 64'(0));
      run_burst("postrst", 100, 2, 0, 2, 4);

      for (int b = 0; b < 1000; b++) begin
         int len;
         len = $urandom_range(0, 16);
         run_burst($sformatf("rnd%0d", b), $urandom_range(0, MEM_DEPTH - 1), len, 2, len, -1);
      end
      check("stability", 64'(stab_err), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
